// File: rtl/rom_byte_streamer.sv
// rom_byte_streamer: walks a fixed RAM window [BASE_ADDR, BASE_ADDR+LENGTH) with one-cycle
// latency reads and presents the bytes as a valid/ready stream through a 3-entry FIFO.
// Build macro STREAMER_STOP_ON_NUL_EN: the first 0x00 byte captured ends the stream early.
module rom_byte_streamer #(
    parameter int unsigned ROM_DEPTH = 256,
    parameter int unsigned BASE_ADDR = 0,
    parameter int unsigned LENGTH    = ROM_DEPTH,
    parameter int unsigned ADDR_W    = (ROM_DEPTH > 1) ? $clog2(ROM_DEPTH) : 1
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Start,
    output logic              Busy,
    output logic              Done,
    output logic [ADDR_W-1:0] RamReadAddr,
    output logic              RamReadEnable,
    input  logic [7:0]        RamReadData,
    output logic              OutValid,
    input  logic              OutReady,
    output logic [7:0]        OutData,
    output logic              OutLast,
    output logic [ADDR_W-1:0] OutIndex
);

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    localparam logic [ADDR_W-1:0] FirstAddr = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LastAddr  = ADDR_W'(BASE_ADDR + LENGTH - 1);
    localparam logic [ADDR_W-1:0] LastIdx   = ADDR_W'(LENGTH - 1);

    if (LENGTH == 0 || BASE_ADDR + LENGTH > ROM_DEPTH) begin : g_cfg_check
        $error("rom_byte_streamer: window BASE_ADDR=%0d LENGTH=%0d does not fit ROM_DEPTH=%0d",
               BASE_ADDR, LENGTH, ROM_DEPTH);
    end

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              inflight_q, inflight_d;
    logic              done_q, done_d;
    logic [7:0]        fifo_q [3];
    logic [7:0]        fifo_d [3];
    logic [1:0]        wr_ptr_q, wr_ptr_d;
    logic [1:0]        rd_ptr_q, rd_ptr_d;
    logic [1:0]        count_q, count_d;

    logic issue;
    logic push;
    logic pop;
    logic head_is_nul;

    // Reads are throttled on buffered + in-flight bytes only, so OutReady never reaches issue.
    assign issue = (state_q == StRun) && (({1'b0, count_q} + {2'b00, inflight_q}) < 3'd3);

`ifdef STREAMER_STOP_ON_NUL_EN
    logic nul_seen_q, nul_seen_d;
    logic push_nul;

    // Once the terminating NUL is captured, anything still returning from the RAM is dropped.
    assign push        = inflight_q && !nul_seen_q;
    assign push_nul    = push && (RamReadData == 8'h00);
    // Only the terminating NUL can ever sit in the FIFO, so a zero head is the last byte.
    assign head_is_nul = (OutData == 8'h00);
`else
    assign push        = inflight_q;
    assign head_is_nul = 1'b0;
`endif

    assign OutValid      = (count_q != 2'd0);
    assign OutData       = fifo_q[rd_ptr_q];
    assign OutIndex      = idx_q;
    assign OutLast       = OutValid && ((idx_q == LastIdx) || head_is_nul);
    assign pop           = OutValid && OutReady;
    assign Busy          = (state_q != StIdle);
    assign Done          = done_q;
    assign RamReadAddr   = addr_q;
    assign RamReadEnable = issue;

    // Next-state logic for the sequencer, read address, FIFO and output index.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        idx_d      = idx_q;
        inflight_d = issue;
        done_d     = 1'b0;
        fifo_d     = fifo_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q + 2'(push) - 2'(pop);
`ifdef STREAMER_STOP_ON_NUL_EN
        nul_seen_d = nul_seen_q || push_nul;
`endif

        if (push) begin
            fifo_d[wr_ptr_q] = RamReadData;
            wr_ptr_d         = (wr_ptr_q == 2'd2) ? 2'd0 : wr_ptr_q + 2'd1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == 2'd2) ? 2'd0 : rd_ptr_q + 2'd1;
            idx_d    = idx_q + ADDR_W'(1);
        end

        unique case (state_q)
            StIdle: begin
                if (Start) begin
                    state_d = StRun;
                    addr_d  = FirstAddr;
                    idx_d   = '0;
`ifdef STREAMER_STOP_ON_NUL_EN
                    nul_seen_d = 1'b0;
`endif
                end
            end
            StRun: begin
                if (issue) begin
                    // Address holds on the final read; the window never wraps.
                    if (addr_q == LastAddr) begin
                        state_d = StDrain;
                    end else begin
                        addr_d = addr_q + ADDR_W'(1);
                    end
                end
`ifdef STREAMER_STOP_ON_NUL_EN
                if (push_nul) begin
                    state_d = StDrain;
                end
`endif
            end
            StDrain: begin
                if (pop && OutLast) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // All state updates; reset flushes the FIFO and in-flight read and returns to idle.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q    <= StIdle;
            addr_q     <= FirstAddr;
            idx_q      <= '0;
            inflight_q <= 1'b0;
            done_q     <= 1'b0;
            fifo_q     <= '{default: 8'h00};
            wr_ptr_q   <= 2'd0;
            rd_ptr_q   <= 2'd0;
            count_q    <= 2'd0;
`ifdef STREAMER_STOP_ON_NUL_EN
            nul_seen_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            idx_q      <= idx_d;
            inflight_q <= inflight_d;
            done_q     <= done_d;
            fifo_q     <= fifo_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
`ifdef STREAMER_STOP_ON_NUL_EN
            nul_seen_q <= nul_seen_d;
`endif
        end
    end

    // A capture into a full FIFO would mean the issue throttle is broken.
    assert property (@(posedge Clk) disable iff (Rst) !(push && !pop && count_q == 2'd3))
        else $error("rom_byte_streamer: FIFO overflow");

endmodule
